// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, immediate formats, control FSM states and
// datapath mux selects used by the multicycle control path.
package riscv_pkg;

    typedef enum logic [2:0] {
        ITYPE = 3'd0,
        STYPE = 3'd1,
        BTYPE = 3'd2,
        UTYPE = 3'd3,
        JTYPE = 3'd4
    } imm_type_e;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef enum logic [4:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I,
        ALUWB, BRANCH, JAL, JALR, JALR_PC, LUI, AUIPC, FAULT
    } ctrl_state_e;

    typedef enum logic [1:0] {
        SRC_A_PC    = 2'd0,
        SRC_A_OLDPC = 2'd1,
        SRC_A_RS1   = 2'd2,
        SRC_A_ZERO  = 2'd3
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'd0,
        SRC_B_IMM  = 2'd1,
        SRC_B_FOUR = 2'd2
    } alu_src_b_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU_REG = 2'd0,
        RES_MEM     = 2'd1,
        RES_ALU_OUT = 2'd2
    } result_src_e;

endpackage

// File: rtl/multicycle_ctrl_branch_cond.sv
// Branch resolution from funct3 and the ALU compare flags.
module branch_cond (
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    output logic       take,
    output logic       illegal
);

    // signedness is already folded into alu_lt by the ALU, so BLT/BLTU and
    // BGE/BGEU share a condition here
    always_comb begin
        take    = 1'b0;
        illegal = 1'b0;
        case (funct3)
            3'b000:         take = alu_zero;
            3'b001:         take = !alu_zero;
            3'b100, 3'b110: take = alu_lt;
            3'b101, 3'b111: take = !alu_lt;
            default:        illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/
// execute/memory/writeback, drives datapath enables and mux selects, and
// traps illegal opcodes or memory timeouts into a sticky FAULT state.
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [2:0] imm_ctrl,
    output logic       fault
);

    // last idle cycle allowed before a pending request is declared dead
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    ctrl_state_e state, next_state;
    logic [7:0]  wait_cnt;
    imm_type_e   imm_q, imm_sel;
    logic        mem_req_c, mem_we_c, ir_write_c, pc_write_c, reg_write_c;
    logic        take, br_illegal, wait_last;

    // funct7_5 only matters to the ALU decoder downstream
    logic unused_ok;
    assign unused_ok = funct7_5;

    branch_cond u_branch_cond (
        .funct3  (funct3),
        .alu_zero(alu_zero),
        .alu_lt  (alu_lt),
        .take    (take),
        .illegal (br_illegal)
    );

    assign wait_last = (wait_cnt == WAIT_LAST);

    // next-state and datapath controls; imm select holds unless a state claims it
    always_comb begin
        next_state  = state;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = SRC_A_PC;
        alu_src_b   = SRC_B_RS2;
        alu_op      = ALU_ADD;
        result_src  = RES_ALU_REG;
        imm_sel     = imm_q;
        case (state)
            FETCH: begin
                mem_req_c = 1'b1;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    result_src = RES_ALU_OUT;
                    next_state = DECODE;
                end else if (wait_last) begin
                    next_state = FAULT;
                end
            end
            DECODE: begin
                // branch target is computed speculatively into the ALU register
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                imm_sel   = BTYPE;
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    OP_R:              next_state = EXEC_R;
                    OP_IMM:            next_state = EXEC_I;
                    OP_BRANCH:         next_state = BRANCH;
                    OP_JAL:            next_state = JAL;
                    OP_JALR:           next_state = JALR;
                    OP_LUI:            next_state = LUI;
                    OP_AUIPC:          next_state = AUIPC;
                    default:           next_state = FAULT;
                endcase
            end
            MEMADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                if (opcode == OP_LOAD) begin
                    imm_sel    = ITYPE;
                    next_state = MEMRD;
                end else begin
                    imm_sel    = STYPE;
                    next_state = MEMWR;
                end
            end
            MEMRD: begin
                mem_req_c = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready)      next_state = MEMWB;
                else if (wait_last) next_state = FAULT;
            end
            MEMWB: begin
                result_src  = RES_MEM;
                reg_write_c = 1'b1;
                next_state  = FETCH;
            end
            MEMWR: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready)      next_state = FETCH;
                else if (wait_last) next_state = FAULT;
            end
            EXEC_R: begin
                alu_src_a  = SRC_A_RS1;
                alu_op     = ALU_FUNCT;
                next_state = ALUWB;
            end
            EXEC_I: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                imm_sel    = ITYPE;
                alu_op     = ALU_FUNCT;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_write_c = 1'b1;
                next_state  = FETCH;
            end
            BRANCH: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALU_SUB;
                if (br_illegal) begin
                    next_state = FAULT;
                end else begin
                    pc_write_c = take;
                    next_state = FETCH;
                end
            end
            JAL: begin
                imm_sel     = JTYPE;
                alu_src_a   = SRC_A_OLDPC;
                alu_src_b   = SRC_B_FOUR;
                reg_write_c = 1'b1;
                pc_write_c  = 1'b1;
                next_state  = FETCH;
            end
            JALR: begin
                // link first: rd = oldPC + 4
                alu_src_a   = SRC_A_OLDPC;
                alu_src_b   = SRC_B_FOUR;
                result_src  = RES_ALU_OUT;
                reg_write_c = 1'b1;
                next_state  = JALR_PC;
            end
            JALR_PC: begin
                // then jump: the datapath clears bit 0 of rs1 + imm
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                imm_sel    = ITYPE;
                result_src = RES_ALU_OUT;
                pc_write_c = 1'b1;
                next_state = FETCH;
            end
            LUI: begin
                imm_sel    = UTYPE;
                alu_src_a  = SRC_A_ZERO;
                alu_src_b  = SRC_B_IMM;
                next_state = ALUWB;
            end
            AUIPC: begin
                imm_sel    = UTYPE;
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_IMM;
                next_state = ALUWB;
            end
            FAULT:   next_state = FAULT;
            default: next_state = FAULT;
        endcase
    end

    // state, held immediate format, and memory-wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            imm_q    <= ITYPE;
            wait_cnt <= 8'd0;
        end else begin
            state <= next_state;
            imm_q <= imm_sel;
            if (next_state != state || !mem_req_c || mem_ready)
                wait_cnt <= 8'd0;
            else
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // strobes are forced low combinationally while reset is asserted so an
    // in-flight request drops immediately
    assign mem_req   = mem_req_c   & rst_n;
    assign mem_we    = mem_we_c    & rst_n;
    assign ir_write  = ir_write_c  & rst_n;
    assign pc_write  = pc_write_c  & rst_n;
    assign reg_write = reg_write_c & rst_n;
    assign imm_ctrl  = imm_sel;
    assign fault     = (state == FAULT);

endmodule
